fpga_spi_cmd_rx: RTL and testbench
==================================

// Module: fpga_spi_cmd_rx
// PURPOSE
//  FPGA-side receiver for the ARM configuration SPI (spck/mosi/ncs). Oversamples the
//  ARM master in the 13.56 MHz domain, assembles 16-bit command words and decodes
//  them into mode, divisor and threshold registers for the hf/lf images. It is the
//  ARM->FPGA counterpart of the FPGA->ARM SSP sample stream.
// PARAMETERS
//  WORD_W      16   bits per command frame (MSB first)
//  CMD_W       4    opcode field width, word[15:12]
//  SYNC_STAGES 2    synchroniser depth on spck/mosi/ncs (>=2)
// PORTS
//  ck_1356meg    in   1   system clock; all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  spck          in   1   SPI clock from ARM, async, mode 0 (sample on rise)
//  mosi          in   1   SPI data from ARM, async
//  ncs           in   1   SPI chip select from ARM, active low, async
//  conf_word     out  12  last SET_CONFREG payload (major [8:6], minor [3:0])
//  divisor       out  8   last SET_DIVISOR payload
//  threshold     out  8   last SET_EDGE_THRESH payload
//  cmd_valid     out  1   1-cycle pulse: a well-formed word was accepted
//  cmd_op        out  4   opcode of word accepted with cmd_valid (held until next)
//  frame_err     out  1   1-cycle pulse: frame closed with bit count != WORD_W
// BEHAVIOUR
//  Reset: conf_word=0, divisor=8'd95, threshold=8'd127, cmd_valid=0, cmd_op=0,
//   frame_err=0; shift reg, bit counter cleared; synchronisers preset to idle
//   (spck=0, mosi=0, ncs=1). Reset mid-frame discards the partial word.
//  Sync: each input through SYNC_STAGES flops; edge detect on last two stages.
//   Requirement: ARM spck <= ck_1356meg/4 (high and low each >= 2 clocks).
//  States: IDLE (ncs_s=1) -> SHIFT on ncs_s fall: clear shreg and bit_cnt.
//   SHIFT: on spck_s rise, shreg <= {shreg[WORD_W-2:0], mosi_s}; bit_cnt++
//   saturating at 31 (5-bit). SHIFT -> IDLE on ncs_s rise:
//   - bit_cnt==WORD_W: decode shreg; cmd_valid=1 and cmd_op=shreg[15:12] next cycle.
//   - else: frame_err=1 next cycle, no register changes, cmd_op unchanged.
//  Simultaneous spck_s rise and ncs_s rise in one cycle: the spck edge is ignored
//   (ncs rise wins); bit count judged on bits already shifted.
//  spck_s rise while in IDLE: ignored. ncs_s fall while in SHIFT impossible.
//  Decode (opcode, payload):
//   4'h1 SET_CONFREG     conf_word <= shreg[11:0]
//   4'h2 SET_DIVISOR     divisor   <= shreg[7:0]
//   4'h3 SET_EDGE_THRESH threshold <= shreg[7:0]
//   other                no register change; cmd_valid still pulses (opcode passes)
//  Latency: register update and cmd_valid both in the clock after ncs_s rise
//   detected, i.e. SYNC_STAGES+2 clocks after the ncs pin rises.
//  Back-to-back frames: a new ncs_s fall right after a rise starts a clean SHIFT;
//   the one-cycle decode is not disturbed.
//  Outputs are registered; no combinational path from pins to outputs.
// STRUCTURE
//  Shared package/include (fpga_pkg): FPGA_CMD_SET_CONFREG/_SET_DIVISOR/
//   _SET_EDGE_THRESH opcodes, reset defaults for divisor/threshold, WORD_W.
//  One sub-module: sync_edge_det (SYNC_STAGES flops + rise/fall pulses), instantiated
//   once each for spck and ncs; mosi uses the same flops without edge outputs.
//  Core FSM, shifter, counter and decode registers live in this module.
// TESTING
//  1 ck_1356meg ticks after reset: frame 16'h1_0C3, spck=clk/8 -> conf_word=12'h0C3,
//    cmd_valid one pulse, cmd_op=1, divisor/threshold stay 95/127.
//  2 Frames 16'h2_05F then 16'h3_0A0 back-to-back (ncs high 4 clk) -> divisor=8'h5F,
//    threshold=8'hA0, two cmd_valid pulses, no frame_err.
//  3 Short frame of 15 bits then long frame of 40 bits -> two frame_err pulses,
//    no cmd_valid, all registers unchanged, counter saturation no wrap to 16.
//  4 Opcode 4'hF word 16'hF_123 -> cmd_valid, cmd_op=4'hF, no register changes.
//  5 Assert reset after 9 bits of 16'h1_FFF, release, send 16'h1_001 -> conf_word=12'h001,
//    no frame_err from the aborted frame.
//  6 17th spck rise coincident with ncs rise at sync output -> edge ignored,
//    word accepted as 16-bit, cmd_valid=1.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared constants for the ARM->FPGA configuration SPI: frame geometry, opcodes,
// register reset defaults and the receiver state encoding.
package fpga_pkg;

    localparam int WORD_W = 16;
    localparam int CMD_W  = 4;
    localparam int CNT_W  = 5;

    localparam logic [CMD_W-1:0] FPGA_CMD_SET_CONFREG     = 4'h1;
    localparam logic [CMD_W-1:0] FPGA_CMD_SET_DIVISOR     = 4'h2;
    localparam logic [CMD_W-1:0] FPGA_CMD_SET_EDGE_THRESH = 4'h3;

    localparam logic [7:0] DIVISOR_RST   = 8'd95;
    localparam logic [7:0] THRESHOLD_RST = 8'd127;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin with registered rise/fall pulses.
// RST_VAL presets the chain to the pin's idle level so no false edge follows reset.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/fpga_spi_cmd_rx.sv
// ARM configuration SPI receiver: oversamples spck/mosi/ncs, assembles MSB-first
// command words and decodes them into the conf/divisor/threshold registers.
module fpga_spi_cmd_rx
    import fpga_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        ck_1356meg,
    input  logic        reset,
    input  logic        spck,
    input  logic        mosi,
    input  logic        ncs,
    output logic [11:0] conf_word,
    output logic [7:0]  divisor,
    output logic [7:0]  threshold,
    output logic        cmd_valid,
    output logic [3:0]  cmd_op,
    output logic        frame_err,
    output spi_state_e  dbg_state
);

    logic spck_rise, spck_lvl_unused, spck_fall_unused;
    logic ncs_rise, ncs_fall, ncs_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_spck (
        .clk(ck_1356meg), .rst(reset), .din(spck),
        .dout(spck_lvl_unused), .rise(spck_rise), .fall(spck_fall_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(ck_1356meg), .rst(reset), .din(ncs),
        .dout(ncs_lvl_unused), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(ck_1356meg), .rst(reset), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       conf_q, conf_d;
    logic [7:0]        div_q, div_d;
    logic [7:0]        thr_q, thr_d;
    logic              valid_q, valid_d;
    logic [CMD_W-1:0]  op_q, op_d;
    logic              err_q, err_d;
    logic [CMD_W-1:0]  rx_op;

    assign rx_op = shreg_q[WORD_W-1 -: CMD_W];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        conf_d  = conf_q;
        div_d   = div_q;
        thr_d   = thr_q;
        valid_d = 1'b0;
        op_d    = op_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_SHIFT;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // Chip-select release takes priority over a coincident clock edge.
                if (ncs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == CNT_W'(WORD_W)) begin
                        valid_d = 1'b1;
                        op_d    = rx_op;
                        case (rx_op)
                            FPGA_CMD_SET_CONFREG:     conf_d = shreg_q[11:0];
                            FPGA_CMD_SET_DIVISOR:     div_d  = shreg_q[7:0];
                            FPGA_CMD_SET_EDGE_THRESH: thr_d  = shreg_q[7:0];
                            default: ;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (spck_rise) begin
                    shreg_d = {shreg_q[WORD_W-2:0], mosi_s};
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            conf_q  <= '0;
            div_q   <= DIVISOR_RST;
            thr_q   <= THRESHOLD_RST;
            valid_q <= 1'b0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            conf_q  <= conf_d;
            div_q   <= div_d;
            thr_q   <= thr_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign conf_word = conf_q;
    assign divisor   = div_q;
    assign threshold = thr_q;
    assign cmd_valid = valid_q;
    assign cmd_op    = op_q;
    assign frame_err = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fpga_spi_cmd_rx.sv
// Randomised scoreboard bench for fpga_spi_cmd_rx: a frame-level model predicts each
// cmd_valid/frame_err event and a monitor compares it when the DUT pulses.
module tb_fpga_spi_cmd_rx;
    import fpga_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spck = 1'b0;
    logic        mosi = 1'b0;
    logic        ncs = 1'b1;
    logic [11:0] conf_word;
    logic [7:0]  divisor;
    logic [7:0]  threshold;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic        frame_err;
    spi_state_e  dbg_state;

    fpga_spi_cmd_rx dut (
        .ck_1356meg(clk), .reset(reset), .spck(spck), .mosi(mosi), .ncs(ncs),
        .conf_word(conf_word), .divisor(divisor), .threshold(threshold),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .frame_err(frame_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Expected event: {is_err, op, conf, div, thr}
    logic [32:0] exp_q[$];

    logic [11:0] m_conf = 12'h000;
    logic [7:0]  m_div  = 8'd95;
    logic [7:0]  m_thr  = 8'd127;
    logic [3:0]  m_op   = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_conf = 12'h000;
        m_div  = 8'd95;
        m_thr  = 8'd127;
        m_op   = 4'h0;
    endtask

    // A frame is a command only if exactly 16 clock rises were seen inside it.
    task automatic model_frame(input logic [63:0] bits, input int n);
        logic [15:0] w;
        w = bits[15:0];
        if (n == 16) begin
            m_op = w[15:12];
            if (w[15:12] == 4'h1) m_conf = w[11:0];
            if (w[15:12] == 4'h2) m_div  = w[7:0];
            if (w[15:12] == 4'h3) m_thr  = w[7:0];
            exp_q.push_back({1'b0, m_op, m_conf, m_div, m_thr});
        end else begin
            exp_q.push_back({1'b1, m_op, m_conf, m_div, m_thr});
        end
    endtask

    // spck = clk/8; coinc adds a 17th spck rise on the same instant ncs releases.
    task automatic send_frame(input logic [63:0] bits, input int n, input bit coinc);
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            repeat (4) @(negedge clk);
            spck = 1'b1;
            repeat (4) @(negedge clk);
            spck = 1'b0;
        end
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        model_frame(bits, n);
        if (coinc) begin
            mosi = 1'b1;
            spck = 1'b1;
            ncs  = 1'b1;
            repeat (4) @(negedge clk);
            spck = 1'b0;
            mosi = 1'b0;
        end else begin
            ncs = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic check_regs(input string name);
        chk({name, "_conf"}, conf_word, m_conf);
        chk({name, "_div"}, divisor, m_div);
        chk({name, "_thr"}, threshold, m_thr);
        chk({name, "_op"}, cmd_op, m_op);
    endtask

    always @(negedge clk) begin
        if (!reset && (cmd_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {cmd_valid, frame_err}, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("ev_cmd_valid", cmd_valid, !e[32]);
                chk("ev_frame_err", frame_err, e[32]);
                chk("ev_cmd_op", cmd_op, e[31:28]);
                chk("ev_conf_word", conf_word, e[27:16]);
                chk("ev_divisor", divisor, e[15:8]);
                chk("ev_threshold", threshold, e[7:0]);
            end
        end
    end

    initial begin
        logic [63:0] bits;
        int          n;
        int          r;
        logic [3:0]  op;

        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_regs("reset");
        chk("reset_cmd_valid", cmd_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_state", dbg_state, ST_IDLE);

        send_frame(64'h10C3, 16, 1'b0);
        wait_drain("t1_drain");
        chk("t1_conf", conf_word, 12'h0C3);
        chk("t1_div", divisor, 8'd95);
        chk("t1_thr", threshold, 8'd127);

        send_frame(64'h205F, 16, 1'b0);
        send_frame(64'h30A0, 16, 1'b0);
        wait_drain("t2_drain");
        chk("t2_div", divisor, 8'h5F);
        chk("t2_thr", threshold, 8'hA0);

        send_frame(64'h1ABC, 15, 1'b0);
        send_frame(64'h12_3456_789A, 40, 1'b0);
        send_frame(64'h1111_2222_3333, 48, 1'b0);
        wait_drain("t3_drain");
        check_regs("t3");

        send_frame(64'hF123, 16, 1'b0);
        wait_drain("t4_drain");
        chk("t4_op", cmd_op, 4'hF);
        check_regs("t4");

        // Abort mid-frame with reset; ncs released while reset is held.
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        bits = 64'h1FFF;
        for (int i = 15; i >= 7; i--) begin
            mosi = bits[i];
            repeat (4) @(negedge clk);
            spck = 1'b1;
            repeat (4) @(negedge clk);
            spck = 1'b0;
        end
        reset = 1'b1;
        ncs = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_regs("t5_reset");
        send_frame(64'h1001, 16, 1'b0);
        wait_drain("t5_drain");
        chk("t5_conf", conf_word, 12'h001);

        send_frame(64'h20C6, 16, 1'b1);
        wait_drain("t6_drain");
        chk("t6_div", divisor, 8'hC6);
        chk("t6_op", cmd_op, 4'h2);

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 5);
            op = (r < 3) ? 4'(r + 1) : 4'($urandom_range(0, 15));
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 24) : 16;
            bits = {$urandom, $urandom};
            bits[15:12] = op;
            send_frame(bits, n, 1'($urandom_range(0, 3) == 0));
        end
        wait_drain("rand_drain");
        check_regs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
